// File: rtl/lab05_pkg.sv
// Shared constants and state encoding for the lab05 half-adder stimulus/check block.
package lab05_pkg;

    localparam int unsigned VEC_COUNT = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_W     = 8;
    localparam int unsigned RES_W     = 2 * VEC_COUNT;

    // {X,Y} per vector for a correct half adder, vector i at bits [2i+1:2i]
    localparam logic [RES_W-1:0] EXPECT_DEFAULT = 8'h68;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/lab05_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled, flags the last cycle of a vector.
module lab05_dwell_cnt
    import lab05_pkg::*;
#(
    parameter int unsigned DWELL = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tc_c = (cnt_q == CNT_W'(DWELL - 1));

    // Wraps to zero on terminal count so it never exceeds DWELL-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lab05_stim_check.sv
// Drives the four half-adder input vectors on A/B, captures X/Y per vector and
// reports per-vector mismatches against EXPECT.
module lab05_stim_check
    import lab05_pkg::*;
#(
    parameter int unsigned      DWELL  = 5,
    parameter logic [RES_W-1:0] EXPECT = EXPECT_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 X,
    input  logic                 Y,
    output logic                 A,
    output logic                 B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [VEC_COUNT-1:0] FAIL_MASK,
    output logic [RES_W-1:0]     RESULT
);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 cap_q, cap_d;
    logic [IDX_W-1:0]     cap_idx_q, cap_idx_d;
    logic                 a_q, a_d, b_q, b_d;
    logic                 busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [VEC_COUNT-1:0] fail_mask_q, fail_mask_d;
    logic [RES_W-1:0]     result_q, result_d;
    logic                 cnt_clr, cnt_en, cnt_tc_c;

    lab05_dwell_cnt #(.DWELL(DWELL)) u_dwell_cnt (
        .clk  (CLK),
        .rst  (RST),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .tc_c (cnt_tc_c)
    );

    // A/B lag the state by one register stage, so X/Y are sampled one cycle
    // after the terminal count, while the vector is still on the pins.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cap_d       = 1'b0;
        cap_idx_d   = cap_idx_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        result_d    = result_q;
        fail_mask_d = fail_mask_q;
        pass_d      = pass_q;

        if (cap_q) begin
            result_d[{cap_idx_q, 1'b0} +: 2] = {X, Y};
            if ({X, Y} != EXPECT[{cap_idx_q, 1'b0} +: 2]) begin
                fail_mask_d[cap_idx_q] = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d     = ST_DRIVE;
                    idx_d       = '0;
                    cnt_clr     = 1'b1;
                    result_d    = '0;
                    fail_mask_d = '0;
                    pass_d      = 1'b0;
                end
            end
            ST_DRIVE: begin
                cnt_en = 1'b1;
                if (cnt_tc_c) begin
                    cap_d     = 1'b1;
                    cap_idx_d = idx_q;
                    if (idx_q == IDX_W'(VEC_COUNT - 1)) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                pass_d  = (fail_mask_d == '0);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        a_d    = (state_q == ST_DRIVE) && idx_q[1];
        b_d    = (state_q == ST_DRIVE) && idx_q[0];
        busy_d = (state_q == ST_DRIVE);
        done_d = (state_q == ST_FINISH);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cap_q       <= 1'b0;
            cap_idx_q   <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_mask_q <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cap_q       <= cap_d;
            cap_idx_q   <= cap_idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_mask_q <= fail_mask_d;
            result_q    <= result_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign FAIL_MASK = fail_mask_q;
    assign RESULT    = result_q;

endmodule

// File: tb/tb_lab05_stim_check.sv
// Scoreboard bench: two instances (DWELL=5 and DWELL=1) driving a modelled
// half adder with optional faults; expectations come from run timing and vector rules.
module tb_lab05_stim_check;

    typedef struct {
        int         done_edge;
        logic [7:0] res;
        logic [3:0] mask;
        logic       pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       x [2], y [2], a [2], b [2];
    logic       busy [2], done [2], pass [2];
    logic [3:0] fmask [2];
    logic [7:0] result [2];

    int unsigned mode [2];
    logic [7:0]  corrupt [2];

    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;
    exp_t sb [2][$];
    int   next_free [2];
    int   busy_lo [2];
    int   busy_hi [2];
    logic       hold_on [2];
    logic [7:0] hold_res [2];
    logic [3:0] hold_mask [2];
    logic       hold_pass [2];

    always #5 clk = ~clk;

    function automatic int dw(input int k);
        return (k == 0) ? 5 : 1;
    endfunction

    // Unit under test: half adder, mode 1 = X stuck at 0, mode 2 = per-vector corruption
    function automatic logic [1:0] uut(input int unsigned m, input logic [7:0] c,
                                       input logic aa, input logic bb);
        logic [1:0] xy;
        logic [2:0] sh;
        xy = {aa ^ bb, aa & bb};
        sh = {aa, bb, 1'b0};
        case (m)
            1: xy[1] = 1'b0;
            2: xy = xy ^ c[sh +: 2];
            default: ;
        endcase
        return xy;
    endfunction

    assign {x[0], y[0]} = uut(mode[0], corrupt[0], a[0], b[0]);
    assign {x[1], y[1]} = uut(mode[1], corrupt[1], a[1], b[1]);

    lab05_stim_check #(.DWELL(5), .EXPECT(8'h68)) u_dut5 (
        .CLK(clk), .RST(rst), .START(start[0]), .X(x[0]), .Y(y[0]),
        .A(a[0]), .B(b[0]), .BUSY(busy[0]), .DONE(done[0]), .PASS(pass[0]),
        .FAIL_MASK(fmask[0]), .RESULT(result[0])
    );

    lab05_stim_check #(.DWELL(1), .EXPECT(8'h68)) u_dut1 (
        .CLK(clk), .RST(rst), .START(start[1]), .X(x[1]), .Y(y[1]),
        .A(a[1]), .B(b[1]), .BUSY(busy[1]), .DONE(done[1]), .PASS(pass[1]),
        .FAIL_MASK(fmask[1]), .RESULT(result[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, k, edge_n, act, exp);
        end
    endtask

    // Reference model: decides acceptance from run length and pushes expected results
    always @(posedge clk) begin : model
        exp_t       e;
        logic       ai, bi;
        logic [1:0] got, gold;
        int         s;
        edge_n = edge_n + 1;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                sb[k].delete();
                next_free[k] = edge_n + 1;
                busy_lo[k]   = 0;
                busy_hi[k]   = -1;
                hold_on[k]   = 1'b1;
                hold_res[k]  = 8'h00;
                hold_mask[k] = 4'h0;
                hold_pass[k] = 1'b0;
            end else if (start[k] && edge_n >= next_free[k]) begin
                e.res  = 8'h00;
                e.mask = 4'h0;
                for (int i = 0; i < 4; i++) begin
                    ai   = ((i / 2) % 2) == 1;
                    bi   = (i % 2) == 1;
                    got  = uut(mode[k], corrupt[k], ai, bi);
                    s    = i / 2 + i % 2;
                    gold = {(s % 2) == 1, (s / 2) == 1};
                    e.res[2*i +: 2] = got;
                    e.mask[i]       = (got != gold);
                end
                e.pass      = (e.mask == 4'h0);
                e.done_edge = edge_n + 4 * dw(k) + 1;
                sb[k].push_back(e);
                next_free[k] = edge_n + 4 * dw(k) + 2;
                busy_lo[k]   = edge_n + 1;
                busy_hi[k]   = edge_n + 4 * dw(k);
                hold_on[k]   = 1'b0;
            end
        end
    end

    // Monitor: per-cycle BUSY/A/B window, DONE against scoreboard, held results
    always @(negedge clk) begin : monitor
        exp_t e;
        logic eb;
        int   vec;
        if (edge_n > 0) begin
            for (int k = 0; k < 2; k++) begin
                eb  = (edge_n >= busy_lo[k]) && (edge_n <= busy_hi[k]);
                vec = eb ? (edge_n - busy_lo[k]) / dw(k) : 0;
                chk("busy", k, 32'(busy[k]), 32'(eb));
                chk("a", k, 32'(a[k]), 32'(eb && ((vec / 2) % 2) == 1));
                chk("b", k, 32'(b[k]), 32'(eb && (vec % 2) == 1));
                if (done[k]) begin
                    if (sb[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected inst%0d cycle %0d: got 1 expected 0", k, edge_n);
                    end else begin
                        e = sb[k].pop_front();
                        chk("done_cycle", k, 32'(edge_n), 32'(e.done_edge));
                        chk("result", k, 32'(result[k]), 32'(e.res));
                        chk("fail_mask", k, 32'(fmask[k]), 32'(e.mask));
                        chk("pass", k, 32'(pass[k]), 32'(e.pass));
                        hold_on[k]   = 1'b1;
                        hold_res[k]  = e.res;
                        hold_mask[k] = e.mask;
                        hold_pass[k] = e.pass;
                    end
                end else if (sb[k].size() > 0 && sb[k][0].done_edge < edge_n) begin
                    checks++;
                    errors++;
                    $display("FAIL done_missing inst%0d cycle %0d: got 0 expected 1 at cycle %0d",
                             k, edge_n, sb[k][0].done_edge);
                    void'(sb[k].pop_front());
                end
                if (hold_on[k]) begin
                    chk("hold_result", k, 32'(result[k]), 32'(hold_res[k]));
                    chk("hold_mask", k, 32'(fmask[k]), 32'(hold_mask[k]));
                    chk("hold_pass", k, 32'(pass[k]), 32'(hold_pass[k]));
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb[0].size() == 0 && sb[1].size() == 0) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout cycle %0d: got pending runs expected none", edge_n);
    endtask

    task automatic pulse(input logic s0, input logic s1);
        @(negedge clk);
        start[0] = s0;
        start[1] = s1;
        @(negedge clk);
        start[0] = 1'b0;
        start[1] = 1'b0;
    endtask

    initial begin
        hold_on   = '{1'b0, 1'b0};
        busy_lo   = '{0, 0};
        busy_hi   = '{-1, -1};
        next_free = '{0, 0};
        mode      = '{0, 0};
        corrupt   = '{8'h00, 8'h00};
        start     = '{1'b0, 1'b0};
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Fault-free run on both instances
        pulse(1'b1, 1'b1);
        wait_idle();

        // X stuck at 0
        mode = '{1, 1};
        pulse(1'b1, 1'b1);
        wait_idle();
        mode = '{0, 0};

        // Reset during cycle 7 of a DWELL=5 run
        pulse(1'b1, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_idle();

        // Reset and start together: reset wins
        @(negedge clk);
        rst   = 1'b1;
        start = '{1'b1, 1'b1};
        @(negedge clk);
        rst   = 1'b0;
        start = '{1'b0, 1'b0};
        repeat (3) @(negedge clk);

        // Start re-pulsed at cycles 3 and 20 of a run
        pulse(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (16) @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_idle();

        // Start held high for 50 cycles
        @(negedge clk);
        start = '{1'b1, 1'b1};
        repeat (50) @(negedge clk);
        start = '{1'b0, 1'b0};
        wait_idle();

        // Random faults, start traffic and occasional resets
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < 2; k++) begin
                mode[k]    = $urandom_range(0, 2);
                corrupt[k] = 8'($urandom);
            end
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                start[0] = ($urandom_range(0, 3) == 0);
                start[1] = ($urandom_range(0, 3) == 0);
                rst      = ($urandom_range(0, 59) == 0);
            end
            @(negedge clk);
            start = '{1'b0, 1'b0};
            rst   = 1'b0;
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
